// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder_if
// Brief    : CPU memory-port req/ack bundle. Byte enables exist only when
//            MEM_RESPONDER_BYTE_EN is defined.
// Revision : 1.0
// ============================================================================
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;
`ifdef MEM_RESPONDER_BYTE_EN
    logic [3:0]  be;

    modport master (output req, we, addr, wdata, be, input rdata, ack, err, busy);
    modport slave  (input req, we, addr, wdata, be, output rdata, ack, err, busy);
`else
    modport master (output req, we, addr, wdata, input rdata, ack, err, busy);
    modport slave  (input req, we, addr, wdata, output rdata, ack, err, busy);
`endif
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Multicycle word memory behind a req/ack handshake with wait
//            states and alignment/range error responses.
//            Optional byte-enable stores: MEM_RESPONDER_BYTE_EN.
// Revision : 1.0
// ============================================================================
module mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  wire            clk,
    input  wire            reset,
    mem_responder_if.slave bus
);
    localparam int         c_depth     = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  r_state, w_state_n;
    logic [3:0]              r_cnt;
    logic                    r_run;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic                    r_ack, r_err;
    logic [31:0]             r_rdata;
    logic [31:0]             r_mem [c_depth];

    logic                    w_accept, w_addr_err, w_access, w_resp_err;
    logic                    w_acc_we;
    logic [ADDR_WIDTH-1:0]   w_acc_idx;
    logic [31:0]             w_acc_wdata;
`ifdef MEM_RESPONDER_BYTE_EN
    logic [3:0]              r_be;
    logic [3:0]              w_acc_be;
`endif

    // r_run stays low while reset is held, so no request can be accepted
    // (and no store can land) on an edge that occurs during reset.
    assign w_accept   = bus.req && r_run;
    assign w_addr_err = (bus.addr[1:0] != 2'b00) ||
                        ((bus.addr >> (ADDR_WIDTH + 2)) != 32'd0);

    // Zero-wait accesses happen on the accepting edge, before the latches update.
    assign w_acc_we    = (r_state == ST_IDLE) ? bus.we                     : r_we;
    assign w_acc_idx   = (r_state == ST_IDLE) ? bus.addr[ADDR_WIDTH+1:2]   : r_idx;
    assign w_acc_wdata = (r_state == ST_IDLE) ? bus.wdata                  : r_wdata;
`ifdef MEM_RESPONDER_BYTE_EN
    assign w_acc_be    = (r_state == ST_IDLE) ? bus.be                     : r_be;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_access   = 1'b0;
        w_resp_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_addr_err) begin
                        w_resp_err = 1'b1;
                        w_state_n  = ST_RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        w_access  = 1'b1;
                        w_state_n = ST_RESP;
                    end else begin
                        w_state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_access  = 1'b1;
                    w_state_n = ST_RESP;
                end
            end
            ST_RESP: w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run   <= 1'b0;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
`ifdef MEM_RESPONDER_BYTE_EN
            r_be    <= 4'd0;
`endif
        end else begin
            r_run <= 1'b1;
            r_ack <= (w_state_n == ST_RESP);
            r_err <= w_resp_err;
            if (r_state == ST_IDLE && w_accept) begin
                r_we    <= bus.we;
                r_idx   <= bus.addr[ADDR_WIDTH+1:2];
                r_wdata <= bus.wdata;
`ifdef MEM_RESPONDER_BYTE_EN
                r_be    <= bus.be;
`endif
                r_cnt   <= (w_state_n == ST_WAIT) ? c_wait_init : 4'd0;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= (r_cnt == 4'd1) ? 4'd0 : r_cnt - 4'd1;
            end
            if (w_access && !w_acc_we) begin
                r_rdata <= r_mem[w_acc_idx];
            end else if (w_resp_err) begin
                r_rdata <= 32'd0;
            end
        end
    end

    // The array has no reset; its contents survive reset pulses.
    always_ff @(posedge clk) begin
        if (w_access && w_acc_we) begin
`ifdef MEM_RESPONDER_BYTE_EN
            for (int b = 0; b < 4; b++) begin
                if (w_acc_be[b]) begin
                    r_mem[w_acc_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
                end
            end
`else
            r_mem[w_acc_idx] <= w_acc_wdata;
`endif
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign bus.busy  = (r_state != ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Directed bench for mem_responder with 2 and 0 wait states.
// Revision : 1.0
// ============================================================================
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_responder_if b2 ();
    mem_responder_if b0 ();

    mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .reset(rst), .bus(b2.slave));
    mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .reset(rst), .bus(b0.slave));

`ifdef MEM_RESPONDER_BYTE_EN
    logic [3:0] tb_be = 4'hF;
    assign b2.be = tb_be;
    assign b0.be = tb_be;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            b2.req = r; b2.we = w; b2.addr = a; b2.wdata = d;
        end else begin
            b0.req = r; b0.we = w; b0.addr = a; b0.wdata = d;
        end
    endtask

    // Runs one transaction; lat is the negedge index (0 = cycle after edge 0)
    // at which ack was seen, or -1 if it never came.
    task automatic txn(input bit sel, input logic w, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic e,
                       output logic [31:0] rd);
        logic ack_s;
        @(negedge clk);
        drive(sel, 1'b1, w, a, d);
        lat = -1; e = 1'b0; rd = 32'd0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            ack_s = sel ? b2.ack : b0.ack;
            if (ack_s) begin
                lat = c;
                e   = sel ? b2.err : b0.err;
                rd  = sel ? b2.rdata : b0.rdata;
                break;
            end
            // Scramble inputs mid-transaction; the latched copies must win.
            drive(sel, 1'b1, ~w, 32'h0000_0003, ~d);
        end
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    int          lat;
    logic        e;
    logic [31:0] rd;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_ack",   b2.ack,   32'd0);
        chk("rst_err",   b2.err,   32'd0);
        chk("rst_busy",  b2.busy,  32'd0);
        chk("rst_rdata", b2.rdata, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Store then load with two wait states.
        txn(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, lat, e, rd);
        chk("st10_lat", lat, 32'd2);
        chk("st10_err", e,   32'd0);
        txn(1'b1, 1'b0, 32'h10, 32'h0, lat, e, rd);
        chk("ld10_lat", lat, 32'd2);
        chk("ld10_err", e,   32'd0);
        chk("ld10_rd",  rd,  32'hDEADBEEF);

        // Misaligned accesses.
        txn(1'b1, 1'b0, 32'h13, 32'h0, lat, e, rd);
        chk("mis_ld_lat", lat, 32'd0);
        chk("mis_ld_err", e,   32'd1);
        chk("mis_ld_rd",  rd,  32'd0);
        txn(1'b1, 1'b1, 32'h11, 32'h55555555, lat, e, rd);
        chk("mis_st_err", e, 32'd1);
        txn(1'b1, 1'b0, 32'h10, 32'h0, lat, e, rd);
        chk("mis_st_keep", rd, 32'hDEADBEEF);

        // Store response holds rdata; out-of-range store must not alias word 0.
        txn(1'b1, 1'b1, 32'h0, 32'h0BADF00D, lat, e, rd);
        chk("st0_hold_rd", rd, 32'hDEADBEEF);
        txn(1'b1, 1'b1, 32'h1000, 32'hFFFFFFFF, lat, e, rd);
        chk("oor_lat", lat, 32'd0);
        chk("oor_err", e,   32'd1);
        chk("oor_rd",  rd,  32'd0);
        txn(1'b1, 1'b0, 32'h0, 32'h0, lat, e, rd);
        chk("oor_keep", rd, 32'h0BADF00D);

        // Reset during WAIT of a store aborts it.
        txn(1'b1, 1'b1, 32'h20, 32'hCAFE0020, lat, e, rd);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678);
        @(negedge clk);
        chk("wait_busy", b2.busy, 32'd1);
        chk("wait_ack",  b2.ack,  32'd0);
        rst = 1'b1;
        #1;
        chk("arst_busy",  b2.busy,  32'd0);
        chk("arst_rdata", b2.rdata, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("arst_ack", b2.ack, 32'd0);
            chk("arst_err", b2.err, 32'd0);
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_ack", b2.ack, 32'd0);
        end
        txn(1'b1, 1'b0, 32'h20, 32'h0, lat, e, rd);
        chk("abort_keep", rd, 32'hCAFE0020);

        // Zero-wait unit: preload then stream loads with req held high.
        txn(1'b0, 1'b1, 32'h0, 32'h00000100, lat, e, rd);
        chk("w0_st_lat", lat, 32'd0);
        txn(1'b0, 1'b1, 32'h4, 32'h00000104, lat, e, rd);
        txn(1'b0, 1'b1, 32'h8, 32'h00000108, lat, e, rd);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stream_ack", b0.ack, (c % 2 == 0) ? 32'd1 : 32'd0);
            if (c % 2 == 0) begin
                chk("stream_rd", b0.rdata, 32'h100 + 32'(4 * (c / 2)));
                b0.addr = 32'(4 * (c / 2 + 1));
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

`ifdef MEM_RESPONDER_BYTE_EN
        tb_be = 4'hF;
        txn(1'b1, 1'b1, 32'h0, 32'hAABBCCDD, lat, e, rd);
        tb_be = 4'b0101;
        txn(1'b1, 1'b1, 32'h0, 32'h11223344, lat, e, rd);
        tb_be = 4'b0000;
        txn(1'b1, 1'b1, 32'h0, 32'h99999999, lat, e, rd);
        chk("be0_ack", lat, 32'd2);
        txn(1'b1, 1'b0, 32'h0, 32'h0, lat, e, rd);
        chk("be_merge", rd, 32'hAA22CC44);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
